seq_shifter: RTL and testbench

Parametrised multi-cycle shifter/rotator, successor to the 8-bit single-step left shifter in the mini-CPU datapath. It accepts an operand, a shift amount and a mode through a start/busy/done handshake, then shifts one bit position per clock. It reports a sticky overflow/lost-bit flag. It sits beside the ALU and is launched by the control unit for multi-bit shift instructions.

---
 rtl/seq_shifter.sv | 108 ++++++++++
 tb/tb_seq_shifter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: one bit position per clock, start/busy/done handshake,
// sticky lost-bit flag for the shifting modes.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   amt,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] Y,
    output logic             ov,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {
        M_SHL = 3'd0,
        M_SHR = 3'd1,
        M_SAR = 3'd2,
        M_ROL = 3'd3,
        M_ROR = 3'd4
    } mode_t;

    state_t           state;
    mode_t            mode_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] step_y;
    logic             step_ov;

    // Reserved encodings fall through to the default: Y and ov hold, timing unchanged.
    always_comb begin
        step_y  = Y;
        step_ov = ov;
        case (mode_q)
            M_SHL: begin
                step_y  = {Y[WIDTH-2:0], 1'b0};
                step_ov = ov | Y[WIDTH-1];
            end
            M_SHR: begin
                step_y  = {1'b0, Y[WIDTH-1:1]};
                step_ov = ov | Y[0];
            end
            M_SAR: begin
                step_y  = {Y[WIDTH-1], Y[WIDTH-1:1]};
                step_ov = ov | Y[0];
            end
            M_ROL: step_y = {Y[WIDTH-2:0], Y[WIDTH-1]};
            M_ROR: step_y = {Y[0], Y[WIDTH-1:1]};
            default: begin
                step_y  = Y;
                step_ov = ov;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= M_SHL;
            cnt    <= '0;
            Y      <= '0;
            ov     <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        Y      <= A;
                        cnt    <= amt;
                        mode_q <= mode_t'(mode);
                        ov     <= 1'b0;
                        if (amt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    Y   <= step_y;
                    ov  <= step_ov;
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed literal cases plus randomized traffic checked
// every cycle against an arithmetic result/timing model.
module tb_seq_shifter;

    localparam int W   = 8;
    localparam int SHW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [SHW-1:0] amt = '0;
    logic [2:0]   mode = '0;
    logic [W-1:0] Y;
    logic         ov;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    seq_shifter #(.WIDTH(W), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .amt(amt), .mode(mode),
        .Y(Y), .ov(ov), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Final result of a whole operation, from shift/rotate arithmetic on the operand.
    function automatic void model(input logic [W-1:0] a, input int n, input int m,
                                  output logic [W-1:0] y, output logic o);
        longint unsigned av = 64'(a);
        longint unsigned msk = (64'd1 << W) - 1;
        longint unsigned low = (64'd1 << n) - 1;
        longint signed   s = longint'($signed(a));
        int r = n % W;
        case (m)
            0: begin y = W'((av << n) & msk); o = ((av << n) >> W) != 0; end
            1: begin y = W'(av >> n); o = (av & low) != 0; end
            2: begin y = W'((s >>> n) & longint'(msk)); o = (av & low) != 0; end
            3: begin y = W'(((av << r) | (av >> (W - r))) & msk); o = 1'b0; end
            4: begin y = W'(((av >> r) | (av << (W - r))) & msk); o = 1'b0; end
            default: begin y = a; o = 1'b0; end
        endcase
    endfunction

    // Timing model in terms of edge numbers: accept at edge k, done in cycle after k+amt.
    int edge_n = 0;
    int acc_edge = 0;
    int done_edge = -10;
    int free_edge = 0;
    bit active = 0;
    bit started = 0;
    logic [W-1:0] res_y = '0;
    logic         res_ov = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            started   = 1;
            active    = 0;
            res_y     = '0;
            res_ov    = 1'b0;
            free_edge = edge_n + 1;
        end else if (started && start && edge_n >= free_edge) begin
            active    = 1;
            acc_edge  = edge_n;
            done_edge = edge_n + int'(amt);
            free_edge = done_edge + 2;
            model(A, int'(amt), int'(mode), res_y, res_ov);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            automatic bit in_op    = active && edge_n >= acc_edge && edge_n <= done_edge;
            automatic bit in_shift = active && edge_n >= acc_edge && edge_n < done_edge;
            chk("busy", busy, in_op);
            chk("done", done, active && edge_n == done_edge);
            if (!in_shift) begin
                chk("Y", Y, res_y);
                chk("ov", ov, res_ov);
            end
        end
    end

    task automatic op(input logic [W-1:0] a, input int n, input int m,
                      input logic [W-1:0] ey, input logic eo, input int poke);
        int lat = 0;
        @(negedge clk);
        start = 1'b1; A = a; amt = SHW'(n); mode = 3'(m);
        @(negedge clk);
        start = 1'b0; A = W'($urandom); mode = 3'($urandom);
        while (!done && lat < 40) begin
            if (lat == poke) begin start = 1'b1; A = '0; amt = SHW'(1); end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, n);
        chk("result_y", Y, ey);
        chk("result_ov", ov, eo);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_y", Y, 0);
        chk("reset_busy", busy, 0);

        op(8'h81, 1, 0, 8'h02, 1'b1, -1);
        op(8'hB4, 3, 1, 8'h16, 1'b1, -1);
        op(8'h90, 2, 2, 8'hE4, 1'b0, -1);
        op(8'h96, 4, 3, 8'h69, 1'b0, -1);
        op(8'h01, 1, 4, 8'h80, 1'b0, -1);
        op(8'h3C, 2, 6, 8'h3C, 1'b0, -1);
        op(8'h5A, 0, 0, 8'h5A, 1'b0, -1);
        op(8'hFF, 7, 0, 8'h80, 1'b1, 3);

        // start held high with amt=0: accepts land two edges apart
        @(negedge clk);
        start = 1'b1; A = 8'h5A; amt = '0; mode = 3'd0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
        end
        start = 1'b0;
        chk("b2b_pulses", pulses, 3);
        @(negedge clk);

        // reset in the middle of an SHR
        start = 1'b1; A = 8'hF0; amt = SHW'(5); mode = 3'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_y", Y, 0);
        chk("abort_ov", ov, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        op(8'h01, 2, 0, 8'h04, 1'b0, -1);

        repeat (3000) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            A     = W'($urandom);
            amt   = SHW'($urandom);
            mode  = 3'($urandom);
            rst   = ($urandom % 97) == 0;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
